// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
//   Program-counter and address-generation unit for the LC-3 datapath.
//   Holds the PC, forms PC+step, computes the ADDR1+ADDR2 effective address
//   and selects the next PC from increment, bus, adder or a small hardware
//   return stack.  The return stack saves PCs on interrupt/trap entry and
//   restores them on RTI.
//
// Ports
//   i_Clk, i_Reset     clock (rising edge) / synchronous active-high reset
//   LD_PC, PCMUX_SEL   PC load enable and next-PC source select
//   ADDR1MUX_SEL       effective-address base: 0 PC, 1 SR1
//   ADDR2MUX_SEL       offset: zero / sext IR[5:0] / IR[8:0] / IR[10:0]
//   PUSH_PC            push the current PC onto the return stack
//   i_ir, i_sr1, i_bus instruction register, SR1 value, shared bus
//   o_pc, o_pc_inc     current PC and PC+INC_STEP
//   o_addr_sum         ADDR1+ADDR2 (to MARMUX)
//   o_stk_top          top stack entry, 0 while empty
//   o_stk_empty/full   stack occupancy flags
//   o_stk_err          sticky overflow/underflow flag (cleared by reset only)
// ----------------------------------------------------------------------------
module pc_unit #(
  parameter int          W         = 16,
  parameter logic [15:0] RESET_PC  = 16'h3000,
  parameter int          INC_STEP  = 1,
  parameter int          STK_DEPTH = 4
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic         LD_PC,
  input  logic [1:0]   PCMUX_SEL,
  input  logic         ADDR1MUX_SEL,
  input  logic [1:0]   ADDR2MUX_SEL,
  input  logic         PUSH_PC,
  input  logic [15:0]  i_ir,
  input  logic [W-1:0] i_sr1,
  input  logic [W-1:0] i_bus,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_pc_inc,
  output logic [W-1:0] o_addr_sum,
  output logic [W-1:0] o_stk_top,
  output logic         o_stk_empty,
  output logic         o_stk_full,
  output logic         o_stk_err
);

  // Pointer counts entries (0..STK_DEPTH); index addresses the storage array.
  localparam int PTR_W = $clog2(STK_DEPTH + 1);
  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [W-1:0]     pc_r;
  logic [PTR_W-1:0] ptr_r;
  logic             err_r;
  logic [W-1:0]     stk_r [STK_DEPTH];

  logic [W-1:0]     pc_nxt_s;
  logic [PTR_W-1:0] ptr_nxt_s;
  logic             err_nxt_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] top_idx_s;
  logic [W-1:0]     addr1_s;
  logic [W-1:0]     addr2_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             unused_ir_s;

  // IR[15:11] never feeds an offset field.
  assign unused_ir_s = ^i_ir[15:11];

  assign empty_s   = (ptr_r == {PTR_W{1'b0}});
  assign full_s    = (ptr_r == PTR_W'(STK_DEPTH));
  // Only meaningful when not empty; wraps harmlessly otherwise.
  assign top_idx_s = IDX_W'(ptr_r - PTR_W'(1));
  assign pop_s     = LD_PC && (PCMUX_SEL == 2'b11);

  assign o_pc        = pc_r;
  assign o_pc_inc    = pc_r + W'(INC_STEP);
  assign o_addr_sum  = addr1_s + addr2_s;
  assign o_stk_top   = empty_s ? {W{1'b0}} : stk_r[top_idx_s];
  assign o_stk_empty = empty_s;
  assign o_stk_full  = full_s;
  assign o_stk_err   = err_r;

  // Effective-address operand selection with sign extension to W bits.
  always_comb begin
    addr1_s = ADDR1MUX_SEL ? i_sr1 : pc_r;
    case (ADDR2MUX_SEL)
      2'b00:   addr2_s = {W{1'b0}};
      2'b01:   addr2_s = {{(W-6){i_ir[5]}},   i_ir[5:0]};
      2'b10:   addr2_s = {{(W-9){i_ir[8]}},   i_ir[8:0]};
      2'b11:   addr2_s = {{(W-11){i_ir[10]}}, i_ir[10:0]};
      default: addr2_s = {W{1'b0}};
    endcase
  end

  // Next PC, stack pointer, error flag and stack write port.
  always_comb begin
    pc_nxt_s  = pc_r;
    ptr_nxt_s = ptr_r;
    err_nxt_s = err_r;
    wr_en_s   = 1'b0;
    wr_idx_s  = {IDX_W{1'b0}};

    if (LD_PC) begin
      case (PCMUX_SEL)
        2'b00:   pc_nxt_s = o_pc_inc;
        2'b01:   pc_nxt_s = i_bus;
        2'b10:   pc_nxt_s = o_addr_sum;
        2'b11: begin
          if (!empty_s) begin
            pc_nxt_s = stk_r[top_idx_s];
          end else begin
            err_nxt_s = 1'b1;   // underflow: PC holds
          end
        end
        default: pc_nxt_s = pc_r;
      endcase
    end else begin
      pc_nxt_s = pc_r;
    end

    if (PUSH_PC) begin
      if (pop_s && !empty_s) begin
        // Swap: old top goes to PC, current PC replaces top, depth unchanged.
        wr_en_s  = 1'b1;
        wr_idx_s = top_idx_s;
      end else if (!full_s) begin
        // Also covers push-with-pop while empty: the push still lands in entry 0.
        wr_en_s   = 1'b1;
        wr_idx_s  = IDX_W'(ptr_r);
        ptr_nxt_s = ptr_r + PTR_W'(1);
      end else begin
        err_nxt_s = 1'b1;       // overflow: push dropped
      end
    end else if (pop_s && !empty_s) begin
      ptr_nxt_s = ptr_r - PTR_W'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // PC, pointer and sticky error register with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pc_r  <= W'(RESET_PC);
      ptr_r <= {PTR_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      pc_r  <= pc_nxt_s;
      ptr_r <= ptr_nxt_s;
      err_r <= err_nxt_s;
    end
  end

  // Stack storage; contents are don't-care after reset because the pointer clears.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset && wr_en_s) begin
      stk_r[wr_idx_s] <= pc_r;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_pc;
  logic [1:0]  pcmux_sel;
  logic        addr1_sel;
  logic [1:0]  addr2_sel;
  logic        push_pc;
  logic [15:0] ir;
  logic [15:0] sr1;
  logic [15:0] bus;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] addr_sum;
  logic [15:0] stk_top;
  logic        stk_empty;
  logic        stk_full;
  logic        stk_err;

  int checks   = 0;
  int failures = 0;

  pc_unit dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .LD_PC        (ld_pc),
    .PCMUX_SEL    (pcmux_sel),
    .ADDR1MUX_SEL (addr1_sel),
    .ADDR2MUX_SEL (addr2_sel),
    .PUSH_PC      (push_pc),
    .i_ir         (ir),
    .i_sr1        (sr1),
    .i_bus        (bus),
    .o_pc         (pc),
    .o_pc_inc     (pc_inc),
    .o_addr_sum   (addr_sum),
    .o_stk_top    (stk_top),
    .o_stk_empty  (stk_empty),
    .o_stk_full   (stk_full),
    .o_stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic ld, input logic [1:0] sel, input logic push);
    ld_pc     = ld;
    pcmux_sel = sel;
    push_pc   = push;
  endtask

  initial begin
    rst = 1'b1; ld_pc = 1'b0; pcmux_sel = 2'b00; addr1_sel = 1'b0; addr2_sel = 2'b00;
    push_pc = 1'b0; ir = 16'h0000; sr1 = 16'h0000; bus = 16'h0000;
    tick();
    rst = 1'b0;
    #1;
    check("reset_pc",    pc,                 16'h3000);
    check("reset_inc",   pc_inc,             16'h3001);
    check("reset_empty", {15'd0, stk_empty}, 16'h0001);
    check("reset_full",  {15'd0, stk_full},  16'h0000);
    check("reset_err",   {15'd0, stk_err},   16'h0000);
    check("reset_top",   stk_top,            16'h0000);

    // 1. sequential increments
    set_ctl(1'b1, 2'b00, 1'b0);
    tick(); check("inc1", pc, 16'h3001); check("inc1_pcinc", pc_inc, 16'h3002);
    tick(); check("inc2", pc, 16'h3002);
    tick(); check("inc3", pc, 16'h3003); check("inc3_pcinc", pc_inc, 16'h3004);

    // LD_PC=0 holds regardless of select
    set_ctl(1'b0, 2'b01, 1'b0); bus = 16'h5555;
    tick(); check("hold", pc, 16'h3003);

    // 2. PC-relative effective address
    set_ctl(1'b1, 2'b01, 1'b0); bus = 16'h3010;
    tick(); check("bus_load", pc, 16'h3010);
    ir = 16'h0FFE; addr1_sel = 1'b0; addr2_sel = 2'b10; set_ctl(1'b1, 2'b10, 1'b0);
    #1; check("addr_off9", addr_sum, 16'h300E);
    tick(); check("adder_load", pc, 16'h300E);

    // other offset modes with SR1 base
    set_ctl(1'b0, 2'b00, 1'b0);
    sr1 = 16'h1000; addr1_sel = 1'b1;
    ir = 16'h0020; addr2_sel = 2'b01; #1; check("addr_off6", addr_sum, 16'h0FE0);
    ir = 16'h0400; addr2_sel = 2'b11; #1; check("addr_off11", addr_sum, 16'h0C00);
    addr2_sel = 2'b00; #1; check("addr_zero", addr_sum, 16'h1000);

    // 3. push on the same edge as a bus load, then return
    set_ctl(1'b1, 2'b01, 1'b0); bus = 16'h3005;
    tick(); check("pc_3005", pc, 16'h3005);
    set_ctl(1'b1, 2'b01, 1'b1); bus = 16'h0180;
    tick(); check("call_pc", pc, 16'h0180); check("call_top", stk_top, 16'h3005);
    check("call_nempty", {15'd0, stk_empty}, 16'h0000);
    set_ctl(1'b1, 2'b11, 1'b0);
    tick(); check("ret_pc", pc, 16'h3005);
    check("ret_empty", {15'd0, stk_empty}, 16'h0001);
    check("ret_err",   {15'd0, stk_err},   16'h0000);

    // 4. fill the stack while incrementing, then overflow
    set_ctl(1'b1, 2'b00, 1'b1);
    tick(); tick(); tick();
    check("fill3_full", {15'd0, stk_full}, 16'h0000);
    tick();
    check("fill4_full", {15'd0, stk_full}, 16'h0001);
    check("fill4_top",  stk_top, 16'h3008);
    check("fill4_pc",   pc,      16'h3009);
    check("fill4_err",  {15'd0, stk_err}, 16'h0000);
    tick();
    check("ovf_err", {15'd0, stk_err}, 16'h0001);
    check("ovf_top", stk_top, 16'h3008);
    check("ovf_pc",  pc,      16'h300A);

    // drain in LIFO order
    set_ctl(1'b1, 2'b11, 1'b0);
    tick(); check("pop1", pc, 16'h3008);
    tick(); check("pop2", pc, 16'h3007);
    tick(); check("pop3", pc, 16'h3006);
    tick(); check("pop4", pc, 16'h3005);
    check("drain_empty", {15'd0, stk_empty}, 16'h0001);

    // 5. underflow, then reset mid-stream with competing controls
    tick(); check("unf_pc", pc, 16'h3005); check("unf_err", {15'd0, stk_err}, 16'h0001);
    rst = 1'b1; set_ctl(1'b1, 2'b01, 1'b1); bus = 16'h1234;
    tick(); rst = 1'b0; set_ctl(1'b0, 2'b00, 1'b0);
    #1;
    check("rst2_pc",    pc,                 16'h3000);
    check("rst2_err",   {15'd0, stk_err},   16'h0000);
    check("rst2_empty", {15'd0, stk_empty}, 16'h0001);
    check("rst2_top",   stk_top,            16'h0000);

    // 6. push+pop swap
    set_ctl(1'b1, 2'b01, 1'b0); bus = 16'h3005; tick();
    set_ctl(1'b0, 2'b00, 1'b1); tick();
    set_ctl(1'b1, 2'b01, 1'b0); bus = 16'h4000; tick();
    check("pre_swap_pc", pc, 16'h4000); check("pre_swap_top", stk_top, 16'h3005);
    set_ctl(1'b1, 2'b11, 1'b1);
    tick();
    check("swap_pc",  pc,      16'h3005);
    check("swap_top", stk_top, 16'h4000);
    check("swap_err", {15'd0, stk_err}, 16'h0000);
    set_ctl(1'b1, 2'b11, 1'b0);
    tick();
    check("swap_depth_pc", pc, 16'h4000);
    check("swap_depth_empty", {15'd0, stk_empty}, 16'h0001);

    // push+pop while empty: pop underflows, push still lands in entry 0
    set_ctl(1'b1, 2'b11, 1'b1);
    tick();
    check("pp_empty_pc",  pc,      16'h4000);
    check("pp_empty_err", {15'd0, stk_err}, 16'h0001);
    check("pp_empty_top", stk_top, 16'h4000);
    check("pp_empty_nempty", {15'd0, stk_empty}, 16'h0000);

    // wrap at the top of the address space
    set_ctl(1'b1, 2'b01, 1'b0); bus = 16'hFFFF; tick();
    check("wrap_inc", pc_inc, 16'h0000);
    set_ctl(1'b1, 2'b00, 1'b0);
    tick(); check("wrap_pc", pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
